serial_subtractor: RTL and testbench

- Bit-serial unsigned subtractor: computes z = x - y, LSB first, one bit per clock, with a single borrow flip-flop.
- Inverse operation of the team's ripple adders. It trades the combinational carry chain for a WIDTH-cycle sequential datapath.
- Start/busy/done handshake. Sits beside the adder blocks in the lab arithmetic set and feeds the board display logic.

---
 rtl/serial_arith_pkg.sv | 12 +
 rtl/serial_subtractor_if.sv | 22 ++
 rtl/full_subtractor.sv | 12 +
 rtl/serial_subtractor.sv | 96 +++++++++
 tb/tb_serial_subtractor.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/serial_arith_pkg.sv
// Shared definitions for the bit-serial arithmetic blocks.
package serial_arith_pkg;

    localparam int DEF_WIDTH = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/busy/done handshake and operand/result bus of the serial subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = serial_arith_pkg::DEF_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] x;
    logic [WIDTH-1:0] y;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] z;
    logic             borrow;

    modport master (
        output start, x, y,
        input  busy, done, z, borrow
    );

    modport slave (
        input  start, x, y,
        output busy, done, z, borrow
    );
endinterface

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with the borrow going out.
module full_subtractor (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    // Borrow when b exceeds a, or when they match and a borrow arrives.
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor z = x - y, LSB first, one bit per clock.
module serial_subtractor
    import serial_arith_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CW    = 3
) (
    input  logic                clk,
    input  logic                rst,
    serial_subtractor_if.slave  bus
);
    state_t           state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic [CW-1:0]    cnt;
    logic             bin;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] z_q;
    logic             borrow_q;

    logic             d;
    logic             bout;
    logic [WIDTH-1:0] res_next;

    // The single bit slice reused every RUN cycle.
    full_subtractor u_fs (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .bin  (bin),
        .d    (d),
        .bout (bout)
    );

    // Difference bits enter at the MSB so bit 0 lands in place after WIDTH shifts.
    assign res_next = {d, res_sr[WIDTH-1:1]};

    // Handshake FSM plus serial datapath; results only update on the final bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            a_sr     <= '0;
            b_sr     <= '0;
            res_sr   <= '0;
            cnt      <= '0;
            bin      <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            z_q      <= '0;
            borrow_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        a_sr   <= bus.x;
                        b_sr   <= bus.y;
                        res_sr <= '0;
                        bin    <= 1'b0;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    res_sr <= res_next;
                    bin    <= bout;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH-1)) begin
                        z_q      <= res_next;
                        borrow_q <= bout;
                        done_q   <= 1'b1;
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: begin
                    done_q <= 1'b0;
                    busy_q <= 1'b0;
                    state  <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.z      = z_q;
    assign bus.borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed testbench for serial_subtractor.
module tb_serial_subtractor;
    localparam int WIDTH = 5;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

    serial_subtractor #(.WIDTH(WIDTH), .CW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation from a point between edges and watch it to completion.
    // lat = index of the first negedge sample with done=1 (sample 1 follows the accept edge).
    // Optionally injects a second start (inj_x, inj_y) on sample inj_at.
    task automatic run_op(input logic [WIDTH-1:0] xi, input logic [WIDTH-1:0] yi,
                          input int inj_at, input logic [WIDTH-1:0] inj_x,
                          input logic [WIDTH-1:0] inj_y,
                          output logic [WIDTH-1:0] rz, output logic rb,
                          output int lat, output int busy_cnt, output int done_cnt,
                          output int z_moves);
        logic [WIDTH-1:0] z0;
        int n;
        bit seen;
        z0 = bus.z;
        lat = -1; busy_cnt = 0; done_cnt = 0; z_moves = 0; n = 0; seen = 0;
        rz = '0; rb = 1'b0;
        bus.start = 1'b1; bus.x = xi; bus.y = yi;
        @(posedge clk);
        #1;
        bus.start = 1'b0; bus.x = ~xi; bus.y = ~yi;
        while (n < 30) begin
            @(negedge clk);
            n++;
            bus.start = 1'b0;
            if (n == inj_at) begin
                bus.start = 1'b1; bus.x = inj_x; bus.y = inj_y;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cnt++;
                if (!seen) begin
                    seen = 1; lat = n; rz = bus.z; rb = bus.borrow;
                end
            end else if (!seen && bus.z !== z0) z_moves++;
            if (seen && !bus.busy) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b0; bus.x = '0; bus.y = '0;
        repeat (2) @(negedge clk);
        n_total++;
        if ({bus.busy, bus.done, bus.z, bus.borrow} !== '0)
            $display("FAIL reset_outputs got busy=%b done=%b z=%0d borrow=%b want all 0",
                     bus.busy, bus.done, bus.z, bus.borrow);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL idle_after_reset busy=%b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [WIDTH-1:0] rz; logic rb; int lat, bc, dc, zm;
        run_op(5'd9, 5'd3, -1, '0, '0, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd6 || rb !== 1'b0) $display("FAIL basic_result z=%0d b=%b want 6/0", rz, rb);
        else n_pass++;
        n_total++;
        if (lat !== WIDTH + 1) $display("FAIL basic_latency got %0d want %0d", lat, WIDTH + 1);
        else n_pass++;
        n_total++;
        if (bc !== 6) $display("FAIL basic_busy_cycles got %0d want 6", bc);
        else n_pass++;
        n_total++;
        if (zm !== 0) $display("FAIL basic_z_hold z moved %0d times want 0", zm);
        else n_pass++;
    endtask

    task automatic test_negative();
        logic [WIDTH-1:0] rz; logic rb; int lat, bc, dc, zm;
        run_op(5'd3, 5'd9, -1, '0, '0, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd26 || rb !== 1'b1) $display("FAIL negative_result z=%0d b=%b want 26/1", rz, rb);
        else n_pass++;
        n_total++;
        if (dc !== 1) $display("FAIL negative_done_pulse got %0d cycles want 1", dc);
        else n_pass++;
        n_total++;
        if (bus.z !== 5'd26 || bus.borrow !== 1'b1)
            $display("FAIL negative_hold_idle z=%0d b=%b want 26/1", bus.z, bus.borrow);
        else n_pass++;
    endtask

    task automatic test_boundaries();
        logic [WIDTH-1:0] rz; logic rb; int lat, bc, dc, zm;
        run_op(5'd31, 5'd31, -1, '0, '0, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd0 || rb !== 1'b0) $display("FAIL equal_31 z=%0d b=%b want 0/0", rz, rb);
        else n_pass++;
        run_op(5'd0, 5'd1, -1, '0, '0, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd31 || rb !== 1'b1) $display("FAIL zero_minus_one z=%0d b=%b want 31/1", rz, rb);
        else n_pass++;
        run_op(5'd31, 5'd0, -1, '0, '0, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd31 || rb !== 1'b0) $display("FAIL max_minus_zero z=%0d b=%b want 31/0", rz, rb);
        else n_pass++;
    endtask

    task automatic test_ignored_start();
        logic [WIDTH-1:0] rz; logic rb; int lat, bc, dc, zm;
        run_op(5'd20, 5'd5, 2, 5'd1, 5'd1, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd15 || rb !== 1'b0) $display("FAIL ignored_start_result z=%0d b=%b want 15/0", rz, rb);
        else n_pass++;
        n_total++;
        if (dc !== 1) $display("FAIL ignored_start_done got %0d pulses want 1", dc);
        else n_pass++;
        repeat (WIDTH + 2) @(negedge clk);
        n_total++;
        if (bus.busy !== 1'b0) $display("FAIL ignored_start_no_restart busy=%b want 0", bus.busy);
        else n_pass++;
    endtask

    task automatic test_reset_mid_op();
        logic [WIDTH-1:0] rz; logic rb; int lat, bc, dc, zm;
        bus.start = 1'b1; bus.x = 5'd17; bus.y = 5'd2;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        n_total++;
        if ({bus.busy, bus.done, bus.z, bus.borrow} !== '0)
            $display("FAIL reset_mid_op got busy=%b done=%b z=%0d borrow=%b want all 0",
                     bus.busy, bus.done, bus.z, bus.borrow);
        else n_pass++;
        @(negedge clk);
        rst = 1'b0;
        repeat (WIDTH + 2) @(negedge clk);
        n_total++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0)
            $display("FAIL reset_no_resume busy=%b done=%b want 0/0", bus.busy, bus.done);
        else n_pass++;
        run_op(5'd4, 5'd4, -1, '0, '0, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd0 || rb !== 1'b0 || dc !== 1)
            $display("FAIL after_reset_op z=%0d b=%b done=%0d want 0/0/1", rz, rb, dc);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [WIDTH-1:0] rz; logic rb; int lat, bc, dc, zm;
        run_op(5'd7, 5'd2, -1, '0, '0, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd5 || rb !== 1'b0) $display("FAIL b2b_first z=%0d b=%b want 5/0", rz, rb);
        else n_pass++;
        // run_op returns right after the first IDLE sample, so this start hits the next edge.
        run_op(5'd10, 5'd12, -1, '0, '0, rz, rb, lat, bc, dc, zm);
        n_total++;
        if (rz !== 5'd30 || rb !== 1'b1) $display("FAIL b2b_second z=%0d b=%b want 30/1", rz, rb);
        else n_pass++;
        n_total++;
        if (zm !== 0) $display("FAIL b2b_z_hold z moved %0d times want 0 (held 5)", zm);
        else n_pass++;
        n_total++;
        if (lat !== WIDTH + 1) $display("FAIL b2b_latency got %0d want %0d", lat, WIDTH + 1);
        else n_pass++;
    endtask

    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_negative();
        test_boundaries();
        test_ignored_start();
        test_reset_mid_op();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
